fsl_to_stream: RTL and testbench
================================

Name: fsl_to_stream

Overview:
- Return path from the FSL compute core to the host stream.
- Deserializes 32-bit FSL result words (5 per record, most-significant word first) into 160-bit records and buffers them in a record FIFO.
- Emits each record as two tagged 128-bit stream words using the same bit-127 tag encoding the host-to-FSL path consumes: bit127=0 carries rec[63:0], bit127=1 carries rec[159:64].
- Single clock domain; the FSL side has no backpressure, so overflow is detected and counted, never stalled.

Parameters:
- DEPTH, 16, record FIFO depth in 160-bit records; power of two, minimum 2.
- DROP_W, 16, width of the dropped-record counter.

Ports:
- clk  input  1  core clock; all logic is on posedge.
- rst  input  1  synchronous reset, active-low.
- fsl_data  input  32  FSL result word.
- fsl_valid  input  1  fsl_data is valid this cycle.
- resync  input  1  discard the partial record and restart at word 0.
- s1o_valid  output  1  s1o_data is valid.
- s1o_rdy  input  1  sink accepts the word.
- s1o_data  output  128  tagged output stream word.
- rec_count  output  32  records emitted, counted after the HI word is accepted.
- drop_count  output  DROP_W  records dropped on FIFO full; saturates at all-ones.
- overflow  output  1  sticky; set on the first drop.
- fifo_level  output  $clog2(DEPTH)+1  records currently held in the FIFO.

Behaviour:
- Reset (rst==0 at posedge):
  - word index = 0, shift register = 0, FIFO empty, state = IDLE.
  - s1o_valid = 0, s1o_data = 0, rec_count = 0, drop_count = 0, overflow = 0, fifo_level = 0.
  - Reset mid-record or mid-output discards everything, including an output word that has not been accepted.
- Deserializer:
  - On fsl_valid, shift fsl_data into the low 32 bits of the 160-bit shift register (shifting left) and increment the word index 0..4.
  - Gaps between valid words are allowed.
  - On the valid word at index 4, the record is complete; push it in the same edge and return the index to 0.
- resync:
  - Forces the word index to 0 and takes priority over fsl_valid in the same cycle; that word is discarded.
  - The FIFO and the output FSM are not affected.
- Push:
  - If fifo_level==DEPTH at the completing edge, drop the record, increment drop_count (saturating) and set overflow.
  - The drop decision uses the registered level, so a pop in the same cycle does not rescue the record.
  - Otherwise write the record; fifo_level increments.
  - A simultaneous push and pop leaves fifo_level unchanged.
- Output FSM, states IDLE, LO, HI:
  - IDLE: if fifo_level!=0, pop the head into the output record register and go to LO. s1o_valid=0 in IDLE.
  - LO: s1o_valid=1, s1o_data={1'b0, 63'h0, rec[63:0]}. On s1o_rdy go to HI.
  - HI: s1o_valid=1, s1o_data={1'b1, 31'h0, rec[159:64]}. On s1o_rdy, increment rec_count (wraps at 2^32). If fifo_level!=0, pop the next record and go to LO in the same edge; else go to IDLE.
  - s1o_data and s1o_valid are registered and held stable until accepted. s1o_valid never drops without a handshake.
- Latency:
  - 5th word sampled at edge E: FIFO holds the record after E.
  - LO word is valid after E+1.
  - Steady state with s1o_rdy held high: 2 stream words per record, no idle cycles; throughput is bounded by the FSL rate of 5 cycles per record.
- fifo_level is registered and reflects pushes and pops of the previous edge.

Test Plan:
- Words 0xAAAA0004,0xAAAA0003,0xAAAA0002,0xAAAA0001,0xAAAA0000 contiguous, s1o_rdy=1 -> LO word = {0, 63'h0, 64'hAAAA0001_AAAA0000}, then HI word = {1, 31'h0, 96'hAAAA0004_AAAA0003_AAAA0002}; rec_count=1; LO valid exactly 2 edges after the 5th word.
- Same 5 words with 3 idle cycles between each -> identical output; no premature s1o_valid.
- s1o_rdy=0 while 17 records arrive with DEPTH=16 -> s1o_valid=1 held with LO of record 1; record 1 is in the output register, so 16 records queue with no drop; 18th record -> drop_count=1, overflow=1. Release s1o_rdy -> 34 stream words in order, rec_count=17, fifo_level returns to 0.
- 2 words, then resync, then 5 words -> exactly one record emitted, built only from the last 5 words.
- resync and fsl_valid in the same cycle -> that word is ignored; word index is 0 afterwards.
- rst=0 asserted while in HI with 3 records queued -> next cycle s1o_valid=0, fifo_level=0, counters 0; a new 5-word record emits normally.

Source files
------------

// File: rtl/fsl_to_stream.sv
// fsl_to_stream: return path from the FSL compute core to the host stream.
//   Packs five 32-bit FSL result words (MS word first) into a 160-bit record,
//   queues records in a DEPTH-entry FIFO and sends each one as two tagged
//   128-bit words: bit127=0 carries rec[63:0], bit127=1 carries rec[159:64].
//   The FSL side cannot be stalled. A record that completes while the FIFO is
//   full is dropped and counted.
// Ports:
//   clk, rst        core clock; synchronous active-low reset
//   fsl_data/valid  incoming FSL result words
//   resync          discard the partial record; the next word is word 0
//   s1o_*           valid/ready output stream, registered, held until accepted
//   rec_count       records fully emitted (HI word accepted), wraps
//   drop_count      records dropped on full FIFO, saturating
//   overflow        sticky, set on the first drop
//   fifo_level      records held in the FIFO (not counting the output register)
module fsl_to_stream #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fsl_data,
  input  logic                     fsl_valid,
  input  logic                     resync,
  output logic                     s1o_valid,
  input  logic                     s1o_rdy,
  output logic [127:0]             s1o_data,
  output logic [31:0]              rec_count,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LO, HI} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [159:0]      sr_q, sr_d;
  logic [159:0]      mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic [95:0]       out_hi_q, out_hi_d;
  logic              valid_q, valid_d;
  logic [127:0]      data_q, data_d;
  logic [31:0]       rec_count_q, rec_count_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;

  logic [159:0] push_rec, head;
  logic         rec_done, full, push, pop;

  assign push_rec = {sr_q[127:0], fsl_data};
  assign head     = mem_q[rptr_q];
  // resync wins over a word arriving in the same cycle
  assign rec_done = fsl_valid && !resync && (idx_q == 3'd4);
  // registered level: a pop in the same cycle cannot make room
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign push     = rec_done && !full;

  always_comb begin
    idx_d        = idx_q;
    sr_d         = sr_q;
    state_d      = state_q;
    out_hi_d     = out_hi_q;
    valid_d      = valid_q;
    data_d       = data_q;
    rec_count_d  = rec_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    pop          = 1'b0;

    if (resync) begin
      idx_d = 3'd0;
    end else if (fsl_valid) begin
      sr_d  = push_rec;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end

    if (rec_done && full) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        data_d  = '0;
        if (level_q != '0) begin
          pop      = 1'b1;
          out_hi_d = head[159:64];
          data_d   = {1'b0, 63'h0, head[63:0]};
          valid_d  = 1'b1;
          state_d  = LO;
        end
      end
      LO: begin
        if (s1o_rdy) begin
          data_d  = {1'b1, 31'h0, out_hi_q};
          state_d = HI;
        end
      end
      HI: begin
        if (s1o_rdy) begin
          rec_count_d = rec_count_q + 32'd1;
          // back-to-back records: load the next LO word without an idle cycle
          if (level_q != '0) begin
            pop      = 1'b1;
            out_hi_d = head[159:64];
            data_d   = {1'b0, 63'h0, head[63:0]};
            state_d  = LO;
          end else begin
            valid_d = 1'b0;
            data_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        data_d  = '0;
        state_d = IDLE;
      end
    endcase

    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sr_q         <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      out_hi_q     <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      rec_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sr_q         <= sr_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      out_hi_q     <= out_hi_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage only; emptiness is carried by the reset pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_rec;
  end

  assign s1o_valid  = valid_q;
  assign s1o_data   = data_q;
  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_fsl_to_stream.sv
module tb_fsl_to_stream;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  fsl_data = '0;
  logic         fsl_valid = 1'b0;
  logic         resync = 1'b0;
  logic         s1o_valid;
  logic         s1o_rdy = 1'b0;
  logic [127:0] s1o_data;
  logic [31:0]  rec_count;
  logic [15:0]  drop_count;
  logic         overflow;
  logic [4:0]   fifo_level;

  fsl_to_stream #(.DEPTH(16), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .fsl_data(fsl_data), .fsl_valid(fsl_valid),
    .resync(resync), .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy),
    .s1o_data(s1o_data), .rec_count(rec_count), .drop_count(drop_count),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: transaction level. Words collect in a list; each group of
  // five becomes a record whose two tagged stream words are queued in order.
  logic [31:0]  mbuf[$];
  logic [127:0] exp_q[$];
  int           exp_recs = 0;
  bit           skip_next = 0;

  task automatic model_word(input logic [31:0] w);
    logic [159:0] rec;
    mbuf.push_back(w);
    if (mbuf.size() == 5) begin
      rec = {mbuf[0], mbuf[1], mbuf[2], mbuf[3], mbuf[4]};
      mbuf.delete();
      if (skip_next) skip_next = 0;
      else begin
        exp_q.push_back({1'b0, 63'h0, rec[63:0]});
        exp_q.push_back({1'b1, 31'h0, rec[159:64]});
        exp_recs++;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    fsl_valid = v; fsl_data = d; resync = r;
    if (r) mbuf.delete();
    else if (v) model_word(d);
    @(posedge clk); #1;
    fsl_valid = 1'b0; resync = 1'b0;
  endtask

  task automatic drain();
    int budget;
    s1o_rdy = 1'b1;
    budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("drain_left", 160'(exp_q.size()), 160'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rec_count", rec_count, exp_recs);
    chk("level_end", fifo_level, 0);
  endtask

  // Output monitor: every accepted word is checked in order; an unaccepted
  // word must hold valid and data.
  logic         pv = 0, pacc = 0;
  logic [127:0] pd = '0;
  logic [127:0] w;
  always @(negedge clk) begin
    if (!rst) pv = 0;
    else begin
      if (pv && !pacc) begin
        chk("hold_valid", s1o_valid, 1);
        chk("hold_data", s1o_data, pd);
      end
      pacc = s1o_valid && s1o_rdy;
      if (pacc) begin
        if (exp_q.size() == 0) chk("unexpected_word", s1o_valid, 0);
        else begin
          w = exp_q.pop_front();
          chk("word", s1o_data, w);
        end
      end
      pv = s1o_valid; pd = s1o_data;
    end
  end

  initial begin
    logic [31:0] t1 [5];
    t1[0] = 32'hAAAA0004; t1[1] = 32'hAAAA0003; t1[2] = 32'hAAAA0002;
    t1[3] = 32'hAAAA0001; t1[4] = 32'hAAAA0000;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_valid", s1o_valid, 0);
    chk("rst_data", s1o_data, 0);
    chk("rst_rec", rec_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", fifo_level, 0);

    // contiguous record, check latency
    s1o_rdy = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, t1[i], 0);
    chk("t1_level", fifo_level, 1);
    chk("t1_early_valid", s1o_valid, 0);
    @(posedge clk); #1;
    chk("t1_lo_valid", s1o_valid, 1);
    chk("t1_lo_data", s1o_data, {1'b0, 63'h0, 64'hAAAA0001_AAAA0000});
    @(posedge clk); #1;
    chk("t1_hi_data", s1o_data, {1'b1, 31'h0, 96'hAAAA0004_AAAA0003_AAAA0002});
    drain();
    chk("t1_rec", rec_count, 1);

    // gapped words: no premature valid
    for (int i = 0; i < 5; i++) begin
      cyc(1, t1[i], 0);
      chk("t2_no_valid", s1o_valid, 0);
      if (i < 4) repeat (3) begin
        cyc(0, 32'h0, 0);
        chk("t2_no_valid", s1o_valid, 0);
      end
    end
    drain();

    // backpressure and overflow
    s1o_rdy = 1'b0;
    for (int r = 0; r < 17; r++)
      for (int j = 0; j < 5; j++) cyc(1, {16'hB000 + 16'(r), 16'(j)}, 0);
    chk("t3_valid", s1o_valid, 1);
    chk("t3_lo_rec1", s1o_data, exp_q[0]);
    chk("t3_level", fifo_level, 16);
    chk("t3_no_drop", drop_count, 0);
    chk("t3_no_ovf", overflow, 0);
    skip_next = 1;
    for (int j = 0; j < 5; j++) cyc(1, {16'hB0FF, 16'(j)}, 0);
    chk("t3_drop", drop_count, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_level_full", fifo_level, 16);
    drain();
    chk("t3_rec", rec_count, 19);

    // resync drops a partial record
    cyc(1, 32'hDEAD0001, 0);
    cyc(1, 32'hDEAD0002, 0);
    cyc(0, 32'h0, 1);
    for (int j = 0; j < 5; j++) cyc(1, 32'hC0DE0000 + j, 0);
    drain();

    // resync with a valid word in the same cycle
    cyc(1, 32'hBAD0BAD0, 1);
    for (int j = 0; j < 5; j++) cyc(1, 32'hF00D0000 + j, 0);
    drain();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      s1o_rdy = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 39) == 0);
    end
    cyc(0, 32'h0, 1);
    drain();
    chk("rnd_drop", drop_count, 1);

    // reset while in HI with records queued
    s1o_rdy = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 5; j++) cyc(1, {16'hE000 + 16'(r), 16'(j)}, 0);
    s1o_rdy = 1'b1;
    @(posedge clk); #1;
    s1o_rdy = 1'b0;
    chk("t6_hi", s1o_data, exp_q[0]);
    chk("t6_level", fifo_level, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); mbuf.delete(); exp_recs = 0;
    chk("t6_valid", s1o_valid, 0);
    chk("t6_level0", fifo_level, 0);
    chk("t6_rec", rec_count, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_ovf", overflow, 0);
    s1o_rdy = 1'b1;
    for (int j = 0; j < 5; j++) cyc(1, 32'h12340000 + j, 0);
    drain();
    chk("t6_rec1", rec_count, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
